fifo_stream_drain: RTL

FIFO_STREAM_DRAIN -- requirements
Module: fifo_stream_drain

---
 rtl/fifo_stream_drain.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fifo_stream_drain.sv
// -----------------------------------------------------------------------------
// fifo_stream_drain
//
// Drains words from a synchronous FIFO with one-cycle read latency and
// presents them on a valid/ready output stream. A two-entry in-order buffer
// absorbs the read latency so that reads already in flight always have
// somewhere to land, even while the consumer is stalling.
//
// Parameters
//   FIFO_WIDTH     word width of the FIFO read data and of the output stream
//   CNT_WIDTH      width of the transferred-word counter
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   en             drain enable; low stops new FIFO reads only
//   fifo_empty     FIFO empty flag
//   fifo_underflow FIFO underflow flag
//   fifo_data_out  FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en     read request to the FIFO
//   m_data         output stream data (buffer head)
//   m_valid        output stream valid
//   m_ready        output stream ready from the consumer
//   word_cnt       count of words accepted by the consumer (wraps)
//   underflow_err  sticky flag, set on any observed FIFO underflow
// -----------------------------------------------------------------------------
module fifo_stream_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  underflow_err
);

  // Buffer occupancy encoding.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  uflow_q, uflow_d;

  logic [2:0]            committed;
  logic                  capture;
  logic                  pop;

  // A read is only issued when the buffer can take every word that is either
  // already stored or still on its way back from the FIFO. This is what keeps
  // occupancy bounded at two without any overflow handling downstream.
  // rst_n gates the request so the FIFO sees no read while reset is held.
  assign committed  = {1'b0, occ_q} + {2'b00, inflight_q};
  assign fifo_rd_en = rst_n & en & ~fifo_empty & (committed < 3'd2);

  assign capture = inflight_q;
  assign pop     = m_valid & m_ready;

  assign m_valid       = (occ_q != OCC_EMPTY);
  assign m_data        = head_q;
  assign word_cnt      = cnt_q;
  assign underflow_err = uflow_q;

  // Buffer update. The head is always the oldest word; on a simultaneous
  // capture and pop the surviving word moves forward before the new word is
  // appended, so order is preserved with occupancy unchanged. Combinations
  // that the read throttle rules out (capture into a full buffer, pop from an
  // empty one) leave the buffer untouched.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({capture, pop})
      2'b10: begin
        case (occ_q)
          OCC_EMPTY: begin
            head_d = fifo_data_out;
            occ_d  = OCC_ONE;
          end
          OCC_ONE: begin
            tail_d = fifo_data_out;
            occ_d  = OCC_TWO;
          end
          default: begin
            occ_d = occ_q;
          end
        endcase
      end
      2'b01: begin
        case (occ_q)
          OCC_ONE: begin
            occ_d = OCC_EMPTY;
          end
          OCC_TWO: begin
            head_d = tail_q;
            occ_d  = OCC_ONE;
          end
          default: begin
            occ_d = occ_q;
          end
        endcase
      end
      2'b11: begin
        case (occ_q)
          OCC_ONE: begin
            head_d = fifo_data_out;
          end
          OCC_TWO: begin
            head_d = tail_q;
            tail_d = fifo_data_out;
          end
          default: begin
            occ_d = occ_q;
          end
        endcase
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // The inflight marker follows the read request by one cycle, matching the
  // FIFO read latency. Counter and sticky error next-state are kept here too.
  always_comb begin
    inflight_d = fifo_rd_en;
    cnt_d      = cnt_q;
    if (pop) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    uflow_d = uflow_q | fifo_underflow;
  end

  // All state clears asynchronously; clearing inflight discards any read that
  // was issued just before reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      uflow_q    <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      uflow_q    <= uflow_d;
    end
  end

endmodule
